// File: rtl/br_pkg.sv
// Shared types and constants for the branch resolve queue.
package br_pkg;

    localparam int BR_ADDR_W     = 32;
    localparam int BR_INST_BYTES = 4;

    // 2-bit local predictor state encodings (strongly not-taken .. strongly taken).
    typedef enum logic [1:0] {
        S_NONTAKEN      = 2'd0,
        S_WEAK_NONTAKEN = 2'd1,
        S_WEAK_TAKEN    = 2'd2,
        S_TAKEN         = 2'd3
    } br_state_e;

    // One in-flight predicted branch.
    typedef struct packed {
        logic [BR_ADDR_W-1:0] pc;
        logic                 taken;
        logic [BR_ADDR_W-1:0] target;
    } br_entry_t;

endpackage

// File: rtl/br_resolve_queue_if.sv
// Fetch push, EX resolve and predictor update / redirect signals of the resolve queue.
interface br_resolve_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              push_valid_i;
    logic [ADDR_W-1:0] push_pc_i;
    logic              push_taken_i;
    logic [ADDR_W-1:0] push_target_i;
    logic              push_ready_o;
    logic              res_valid_i;
    logic              res_taken_i;
    logic [ADDR_W-1:0] res_target_i;
    logic              upd_valid_o;
    logic              upd_taken_o;
    logic [ADDR_W-1:0] upd_pc_o;
    logic              flush_o;
    logic [ADDR_W-1:0] redirect_pc_o;
    logic [CW-1:0]     count_o;
    logic [CNT_W-1:0]  resolved_cnt_o;
    logic [CNT_W-1:0]  mispred_cnt_o;
    logic [1:0]        err_o;

    modport master (
        output push_valid_i, push_pc_i, push_taken_i, push_target_i,
        output res_valid_i, res_taken_i, res_target_i,
        input  push_ready_o, upd_valid_o, upd_taken_o, upd_pc_o, flush_o,
        input  redirect_pc_o, count_o, resolved_cnt_o, mispred_cnt_o, err_o
    );

    modport slave (
        input  push_valid_i, push_pc_i, push_taken_i, push_target_i,
        input  res_valid_i, res_taken_i, res_target_i,
        output push_ready_o, upd_valid_o, upd_taken_o, upd_pc_o, flush_o,
        output redirect_pc_o, count_o, resolved_cnt_o, mispred_cnt_o, err_o
    );

endinterface

// File: rtl/br_fifo.sv
// DEPTH-entry synchronous FIFO of branch entries with a single-cycle clear.
module br_fifo
    import br_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  br_entry_t                  push_data,
    input  logic                       pop,
    input  logic                       clear,
    output br_entry_t                  head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    br_entry_t       mem_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= PW'(0);
            wr_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else if (clear) begin
            rd_ptr_r <= PW'(0);
            wr_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; when full, a push with a pop reuses the slot being popped.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/br_resolve_queue.sv
// In-order branch resolve queue: compares the oldest prediction with the EX outcome,
// drives the predictor update port and issues flush/redirect on a mispredict.
module br_resolve_queue
    import br_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = BR_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    br_resolve_queue_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    br_entry_t         head_s;
    br_entry_t         push_entry_s;
    logic [CW-1:0]     count_s;
    logic              full_s;
    logic              empty_s;
    logic              res_acc_s;
    logic              push_acc_s;
    logic              mispred_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_clear_s;
    logic              overflow_s;
    logic              underflow_s;
    logic [ADDR_W-1:0] redirect_next_s;

    logic              upd_valid_r;
    logic              upd_taken_r;
    logic [ADDR_W-1:0] upd_pc_r;
    logic              flush_r;
    logic [ADDR_W-1:0] redirect_pc_r;
    logic [CNT_W-1:0]  resolved_cnt_r;
    logic [CNT_W-1:0]  mispred_cnt_r;
    logic [1:0]        err_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    br_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push_s),
        .push_data (push_entry_s),
        .pop       (fifo_pop_s),
        .clear     (fifo_clear_s),
        .head      (head_s),
        .count     (count_s)
    );

    // Accept/compare decisions for the current cycle's push and resolve.
    always_comb begin
        full_s       = (count_s == CW'(DEPTH));
        empty_s      = (count_s == CW'(0));
        res_acc_s    = bus.res_valid_i && !empty_s;
        underflow_s  = bus.res_valid_i && empty_s;
        push_acc_s   = bus.push_valid_i && (!full_s || res_acc_s);
        overflow_s   = bus.push_valid_i && full_s && !res_acc_s;
        push_entry_s = '{pc: bus.push_pc_i, taken: bus.push_taken_i, target: bus.push_target_i};
        if (head_s.taken != bus.res_taken_i) begin
            mispred_s = 1'b1;
        end else if (head_s.taken && (head_s.target != bus.res_target_i)) begin
            mispred_s = 1'b1;
        end else begin
            mispred_s = 1'b0;
        end
        // A mispredict wipes every younger entry, including one pushed this cycle.
        fifo_clear_s = res_acc_s && mispred_s;
        fifo_pop_s   = res_acc_s && !mispred_s;
        fifo_push_s  = push_acc_s && !fifo_clear_s;
        if (bus.res_taken_i) begin
            redirect_next_s = bus.res_target_i;
        end else begin
            redirect_next_s = head_s.pc + ADDR_W'(BR_INST_BYTES);
        end
    end

    // Registered predictor update, flush/redirect, statistics and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_r    <= 1'b0;
            upd_taken_r    <= 1'b0;
            upd_pc_r       <= ADDR_W'(0);
            flush_r        <= 1'b0;
            redirect_pc_r  <= ADDR_W'(0);
            resolved_cnt_r <= CNT_W'(0);
            mispred_cnt_r  <= CNT_W'(0);
            err_r          <= 2'b00;
        end else begin
            upd_valid_r <= res_acc_s;
            flush_r     <= fifo_clear_s;
            err_r       <= err_r | {overflow_s, underflow_s};
            if (res_acc_s) begin
                upd_taken_r    <= bus.res_taken_i;
                upd_pc_r       <= head_s.pc;
                resolved_cnt_r <= sat_inc(resolved_cnt_r);
            end
            if (fifo_clear_s) begin
                redirect_pc_r <= redirect_next_s;
                mispred_cnt_r <= sat_inc(mispred_cnt_r);
            end
        end
    end

    assign bus.push_ready_o   = !full_s;
    assign bus.count_o        = count_s;
    assign bus.upd_valid_o    = upd_valid_r;
    assign bus.upd_taken_o    = upd_taken_r;
    assign bus.upd_pc_o       = upd_pc_r;
    assign bus.flush_o        = flush_r;
    assign bus.redirect_pc_o  = redirect_pc_r;
    assign bus.resolved_cnt_o = resolved_cnt_r;
    assign bus.mispred_cnt_o  = mispred_cnt_r;
    assign bus.err_o          = err_r;

endmodule
